// File: rtl/lfsr10_checker.sv
// Sequence checker for the 10-bit LFSR state stream: predicts each word, counts mismatches and measures period.
// Optional visited-word bitmap and distinct-word counter enabled by defining LFSR10_CHECK_HIST_EN.
module lfsr10_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             restart,
  input  logic             in_valid,
  input  logic [9:0]       in_data,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [10:0]      unique_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [9:0] lfsr_next(input logic [9:0] r);
    lfsr_next = {r[8],
                 r[7] ^ r[6] ^ r[5] ^ r[4] ^ r[3],
                 r[6:0],
                 r[9] ^ r[8] ^ r[7] ^ r[2] ^ r[1]};
  endfunction

  state_t           cur_state;
  logic [9:0]       pred;
  logic [9:0]       anchor;
  logic [CNT_W-1:0] n_cnt;
  logic [CNT_W-1:0] n_inc;
  logic [CNT_W-1:0] err_inc;
  logic             mismatch;

  assign mismatch = (in_data != pred);
  assign n_inc    = (n_cnt == CNT_MAX) ? CNT_MAX : n_cnt + CNT_ONE;
  assign err_inc  = (err_count == CNT_MAX) ? CNT_MAX : err_count + CNT_ONE;
  assign state    = cur_state;

  // A mismatch in RUN re-anchors; once LOCKED the period is frozen and only errors accumulate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state    <= IDLE;
      pred         <= '0;
      anchor       <= '0;
      n_cnt        <= '0;
      err          <= 1'b0;
      err_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else if (restart) begin
      cur_state    <= IDLE;
      pred         <= '0;
      anchor       <= '0;
      n_cnt        <= '0;
      err          <= 1'b0;
      err_count    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else if (in_valid) begin
      pred <= lfsr_next(in_data);
      case (cur_state)
        IDLE: begin
          anchor    <= in_data;
          n_cnt     <= '0;
          cur_state <= RUN;
        end
        RUN: begin
          if (mismatch) begin
            err       <= 1'b1;
            err_count <= err_inc;
            anchor    <= in_data;
            n_cnt     <= '0;
          end else begin
            n_cnt <= n_inc;
            if (in_data == anchor) begin
              period       <= n_inc;
              period_valid <= 1'b1;
              cur_state    <= LOCKED;
            end else if (n_inc == CNT_MAX) begin
              timeout <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (mismatch) begin
            err       <= 1'b1;
            err_count <= err_inc;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

`ifdef LFSR10_CHECK_HIST_EN
  logic [1023:0] visited;
  logic [10:0]   uniq;

  // Counts every first sighting, whatever the checker state, including the anchor sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      visited <= '0;
      uniq    <= '0;
    end else if (restart) begin
      visited <= '0;
      uniq    <= '0;
    end else if (in_valid && !visited[in_data]) begin
      visited[in_data] <= 1'b1;
      uniq             <= uniq + 11'd1;
    end
  end

  assign unique_count = uniq;
`else
  assign unique_count = 11'd0;
`endif

endmodule

// File: tb/tb_lfsr10_checker.sv
// Randomized bench for lfsr10_checker: two instances (CNT_W=16 and CNT_W=4) against a sample-history reference model.
// Distinct-word expectations follow LFSR10_CHECK_HIST_EN when it is defined for the build.
module tb_lfsr10_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  in_data = '0;

  logic        err0, pv0, to0;
  logic [15:0] err_count0, period0;
  logic [10:0] uc0;
  logic [1:0]  st0;
  logic        err1, pv1, to1;
  logic [3:0]  err_count1, period1;
  logic [10:0] uc1;
  logic [1:0]  st1;

  logic [47:0] act0, act1;
  assign act0 = {err0, err_count0, period0, pv0, to0, uc0, st0};
  assign act1 = {err1, 12'd0, err_count1, 12'd0, period1, pv1, to1, uc1, st1};

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lfsr10_checker #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .err(err0), .err_count(err_count0), .period(period0), .period_valid(pv0),
    .timeout(to0), .unique_count(uc0), .state(st0));

  lfsr10_checker #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .restart(restart), .in_valid(in_valid), .in_data(in_data),
    .err(err1), .err_count(err_count1), .period(period1), .period_valid(pv1),
    .timeout(to1), .unique_count(uc1), .state(st1));

  // Reference model: per instance, the last word seen, the anchor and the number of matches since it.
  int m_state[2], m_last[2], m_anchor[2], m_matches[2], m_errs[2], m_period[2];
  bit m_err[2], m_pv[2], m_to[2];
  int m_max[2] = '{65535, 15};
  bit seen[1024];
  int m_uniq;

  function automatic int bit_of(int r, int i);
    return (r >> i) & 1;
  endfunction

  function automatic int f(int r);
    int n;
    n = bit_of(r, 9) ^ bit_of(r, 8) ^ bit_of(r, 7) ^ bit_of(r, 2) ^ bit_of(r, 1);
    for (int i = 1; i <= 7; i++) n += bit_of(r, i - 1) * (1 << i);
    n += (bit_of(r, 7) ^ bit_of(r, 6) ^ bit_of(r, 5) ^ bit_of(r, 4) ^ bit_of(r, 3)) * 256;
    n += bit_of(r, 8) * 512;
    return n;
  endfunction

  function automatic int sat(int x, int mx);
    return (x > mx) ? mx : x;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_state[m] = 0; m_last[m] = 0; m_anchor[m] = 0; m_matches[m] = 0;
      m_errs[m] = 0; m_period[m] = 0; m_err[m] = 0; m_pv[m] = 0; m_to[m] = 0;
    end
    for (int i = 0; i < 1024; i++) seen[i] = 0;
    m_uniq = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit rs);
    if (rs) begin
      model_reset();
    end else if (v) begin
      if (!seen[d]) begin
        seen[d] = 1;
        m_uniq++;
      end
      for (int m = 0; m < 2; m++) begin
        case (m_state[m])
          0: begin
            m_anchor[m] = d; m_matches[m] = 0; m_state[m] = 1;
          end
          1: begin
            if (d != f(m_last[m])) begin
              m_err[m] = 1; m_errs[m]++; m_anchor[m] = d; m_matches[m] = 0;
            end else begin
              m_matches[m]++;
              if (d == m_anchor[m]) begin
                m_period[m] = sat(m_matches[m], m_max[m]); m_pv[m] = 1; m_state[m] = 2;
              end else if (m_matches[m] >= m_max[m]) begin
                m_to[m] = 1;
              end
            end
          end
          default: begin
            if (d != f(m_last[m])) begin
              m_err[m] = 1; m_errs[m]++;
            end
          end
        endcase
        m_last[m] = d;
      end
    end
  endtask

  function automatic logic [47:0] exp_vec(int m);
    logic [15:0] ec, per;
    logic [10:0] uq;
    ec  = 16'(sat(m_errs[m], m_max[m]));
    per = 16'(m_period[m]);
`ifdef LFSR10_CHECK_HIST_EN
    uq = 11'(m_uniq);
`else
    uq = 11'd0;
`endif
    return {m_err[m], ec, per, m_pv[m], m_to[m], uq, 2'(m_state[m])};
  endfunction

  task automatic cycle(input bit v, input int d, input bit rs);
    in_valid = v;
    in_data  = 10'(d);
    restart  = rs;
    @(posedge clock);
    model_step(v, d, rs);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
        errors++;
        $display("[TB] FAIL reset dut%0d actual=%h required=%h", m, (m == 0 ? act0 : act1), exp_vec(m));
      end
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_a0_stream();
    int cur, sent, iter;
    cycle(0, 0, 1);
    cur = 'hA0; sent = 0; iter = 0;
    while (sent < 2000) begin
      if ($urandom_range(0, 3) != 0) begin
        cycle(1, cur, 0);
        cur = f(cur);
        sent++;
      end else begin
        cycle(0, $urandom_range(0, 1023), 0);
      end
      iter++;
      if (iter % 50 == 0 || sent == 2000) begin
        for (int m = 0; m < 2; m++) begin
          checks++;
          if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
            errors++;
            $display("[TB] FAIL a0_stream dut%0d sent=%0d actual=%h required=%h", m, sent, (m == 0 ? act0 : act1), exp_vec(m));
          end
        end
      end
    end
  endtask

  task automatic test_constant_zero();
    cycle(0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 0, 0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
          errors++;
          $display("[TB] FAIL const_zero dut%0d sample=%0d actual=%h required=%h", m, k, (m == 0 ? act0 : act1), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_mismatch();
    int words[5];
    words = '{'h001, 'h002, 'h004, 'h3FF, 0};
    words[4] = f('h3FF);
    cycle(0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(1, words[k], 0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
          errors++;
          $display("[TB] FAIL mismatch dut%0d word=%h actual=%h required=%h", m, words[k], (m == 0 ? act0 : act1), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_restart();
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 'h055, 1);
    cycle(1, 'h055, 0);
    cycle(1, f('h055), 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
        errors++;
        $display("[TB] FAIL restart dut%0d actual=%h required=%h", m, (m == 0 ? act0 : act1), exp_vec(m));
      end
    end
    cycle(0, 0, 1);
    checks++;
    if (st0 !== 2'd0 || err_count0 !== 16'd0 || period0 !== 16'd0) begin
      errors++;
      $display("[TB] FAIL restart_clear actual=%h required state/err_count/period zero", act0);
    end
  endtask

  task automatic test_timeout();
    int cur;
    cycle(0, 0, 1);
    cur = 'hA0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, cur, 0);
      cur = f(cur);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
          errors++;
          $display("[TB] FAIL timeout dut%0d sample=%0d actual=%h required=%h", m, k, (m == 0 ? act0 : act1), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_back_to_back_random();
    int cur, r;
    cycle(0, 0, 1);
    cur = $urandom_range(0, 1023);
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        cycle(1, $urandom_range(0, 1023), 1);
        cur = $urandom_range(0, 1023);
      end else if (r < 12) begin
        r = $urandom_range(0, 1023);
        cycle(1, r, 0);
        cur = f(r);
      end else if (r < 25) begin
        cycle(0, $urandom_range(0, 1023), 0);
      end else begin
        cycle(1, cur, 0);
        cur = f(cur);
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
          errors++;
          $display("[TB] FAIL random dut%0d step=%0d actual=%h required=%h", m, k, (m == 0 ? act0 : act1), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int cur;
    cycle(0, 0, 1);
    cur = 'h2C3;
    repeat (5) begin
      cycle(1, cur, 0);
      cur = f(cur);
    end
    cycle(1, 'h111, 0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
        errors++;
        $display("[TB] FAIL async_reset dut%0d actual=%h required=%h", m, (m == 0 ? act0 : act1), exp_vec(m));
      end
    end
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    cycle(1, 'h123, 0);
    cycle(1, f('h123), 0);
    cycle(1, 'h123, 0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ((m == 0 ? act0 : act1) !== exp_vec(m)) begin
        errors++;
        $display("[TB] FAIL post_reset dut%0d actual=%h required=%h", m, (m == 0 ? act0 : act1), exp_vec(m));
      end
    end
  endtask

  initial begin
    test_reset();
    test_a0_stream();
    test_constant_zero();
    test_mismatch();
    test_restart();
    test_timeout();
    test_back_to_back_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
